// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the two response channels and the
// shared-ALU hookup of alu_arbiter.
//
// Handshake semantics (applies to every valid/ready pair in this bundle):
//   A transfer happens on a rising clk edge where valid && ready are both
//   high. The producer may raise or drop valid at any time before the transfer.
//   Payload is only meaningful while valid is high. ready may depend
//   combinationally on valid, but valid never depends on ready.
interface alu_arbiter_if #(
  parameter int WIDTH = 64
);
  // requester 0
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  // requester 1
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  // response channels share one data bus
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  // shared ALU
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [1:0]       alu_signal;
  logic [WIDTH-1:0] alu_out;
  // status
  logic             busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    input  rsp0_ready, rsp1_ready,
    output alu_in1, alu_in2, alu_signal,
    input  alu_out,
    output busy
  );

  // Environment side: requesters plus the ALU.
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    output rsp0_ready, rsp1_ready,
    input  alu_in1, alu_in2, alu_signal,
    output alu_out,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation is in flight at a time: IDLE accepts a request, EXEC lets the
// registered operands settle through the ALU and captures the result, RESP
// presents the result to the owning requester until it is taken.
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             owner_q;     // requester whose operation is in flight
  logic             last_q;      // requester granted most recently
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic [1:0]       sig_q;
  logic [WIDTH-1:0] result_q;

  logic             grant_valid;
  logic             grant_id;
  logic             accept;      // handshake with the granted requester
  logic             rsp_take;    // owner takes its result

  // Round-robin grant: a lone valid wins; on contention the requester that
  // was not granted last wins. Re-evaluated every cycle so a requester that
  // drops valid before its handshake simply loses the grant.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_q;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  // Next-state and handshake outputs; readies only in IDLE, responses only
  // in RESP and only toward the owner.
  always_comb begin
    state_d        = state_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    accept         = 1'b0;
    rsp_take       = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req0_ready = grant_valid & ~grant_id;
        bus.req1_ready = grant_valid &  grant_id;
        // Grant implies the granted requester is valid, so grant == handshake.
        accept = grant_valid;
        if (grant_valid) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        bus.rsp0_valid = ~owner_q;
        bus.rsp1_valid =  owner_q;
        // The non-owner's rsp_ready is deliberately not looked at.
        rsp_take = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_take) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand/opcode capture on handshake; held until the next handshake so the
  // ALU inputs stay stable through EXEC and RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1_q   <= '0;
      in2_q   <= '0;
      sig_q   <= 2'b00;
      owner_q <= 1'b0;
      last_q  <= 1'b1;   // requester 0 wins the first contention
    end else if (accept) begin
      in1_q   <= grant_id ? bus.req1_a  : bus.req0_a;
      in2_q   <= grant_id ? bus.req1_b  : bus.req0_b;
      sig_q   <= grant_id ? bus.req1_op : bus.req0_op;
      owner_q <= grant_id;
      last_q  <= grant_id;
    end
  end

  // Result capture at the end of EXEC; the ALU output is taken as-is,
  // including whatever it returns for reserved op codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (state_q == EXEC) begin
      result_q <= bus.alu_out;
    end
  end

  // Output drive.
  always_comb begin
    bus.alu_in1    = in1_q;
    bus.alu_in2    = in2_q;
    bus.alu_signal = sig_q;
    bus.rsp_data   = result_q;
    bus.busy       = (state_q != IDLE);
    state_dbg      = state_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single transactions plus
// hand-written sequences for round robin, response back-pressure, reset in
// flight and the reset value of the grant pointer.
module tb_alu_arbiter;
  localparam int WIDTH = 64;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  int n_pass;
  int n_total;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Reference shared ALU: add, sub, zero for reserved codes.
  always_comb begin
    case (bus.alu_signal)
      2'b00:   bus.alu_out = bus.alu_in1 + bus.alu_in2;
      2'b01:   bus.alu_out = bus.alu_in1 - bus.alu_in2;
      default: bus.alu_out = '0;
    endcase
  end

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int              port;
    logic [1:0]      op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req0_op = 2'b00;
    bus.req1_a = '0;
    bus.req1_b = '0;
    bus.req1_op = 2'b00;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int port, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (port == 0) begin
      bus.req0_valid = 1'b1;
      bus.req0_op = op;
      bus.req0_a = a;
      bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1;
      bus.req1_op = op;
      bus.req1_a = a;
      bus.req1_b = b;
    end
  endtask

  // One full transaction from IDLE; starts and ends just after a rising edge.
  task automatic do_txn(input int port, input logic [1:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp);
    logic own_rdy, oth_rdy, own_rv, oth_rv;
    set_req(port, op, a, b);
    bus.rsp0_ready = (port == 0);
    bus.rsp1_ready = (port == 1);
    // cycle T
    @(negedge clk);
    own_rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
    oth_rdy = (port == 0) ? bus.req1_ready : bus.req0_ready;
    check($sformatf("req%0d_ready at T", port), {63'd0, own_rdy}, 64'd1);
    check("other ready at T", {63'd0, oth_rdy}, 64'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    // cycle T+1
    @(negedge clk);
    own_rv = (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    check("busy at T+1", {63'd0, bus.busy}, 64'd1);
    check("rsp_valid at T+1", {63'd0, own_rv}, 64'd0);
    tick();
    // cycle T+2
    @(negedge clk);
    own_rv = (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    oth_rv = (port == 0) ? bus.rsp1_valid : bus.rsp0_valid;
    check($sformatf("rsp%0d_valid at T+2", port), {63'd0, own_rv}, 64'd1);
    check("other rsp_valid at T+2", {63'd0, oth_rv}, 64'd0);
    check("rsp_data", bus.rsp_data, exp);
    tick();
    // cycle T+3: back in IDLE, ALU inputs held
    @(negedge clk);
    check("busy at T+3", {63'd0, bus.busy}, 64'd0);
    check("alu_in1 held", bus.alu_in1, a);
    check("alu_in2 held", bus.alu_in2, b);
    check("alu_signal held", {62'd0, bus.alu_signal}, {62'd0, op});
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    tick();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    clear_inputs();

    vecs[0] = '{0, 2'b00, 64'd5, 64'd7, 64'd12};
    vecs[1] = '{1, 2'b01, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{0, 2'b10, 64'd9, 64'd9, 64'd0};
    vecs[3] = '{1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
    vecs[4] = '{0, 2'b01, 64'd100, 64'd58, 64'd42};
    vecs[5] = '{1, 2'b11, 64'd4, 64'd4, 64'd0};
    vecs[6] = '{0, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0};
    vecs[7] = '{1, 2'b01, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};

    // reset state
    do_reset();
    @(negedge clk);
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset state", {62'd0, state_dbg}, 64'd0);
    check("reset alu_in1", bus.alu_in1, 64'd0);
    check("reset alu_in2", bus.alu_in2, 64'd0);
    check("reset alu_signal", {62'd0, bus.alu_signal}, 64'd0);
    check("reset rsp_data", bus.rsp_data, 64'd0);
    check("reset rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
    check("reset rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
    tick();

    // vector table
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // round robin from reset: grants 0,1,0,1 three cycles apart
    do_reset();
    set_req(0, 2'b00, 64'd1, 64'd1);
    set_req(1, 2'b00, 64'd2, 64'd2);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      logic e0, e1;
      e0 = (cyc % 3 == 0) && ((cyc / 3) % 2 == 0);
      e1 = (cyc % 3 == 0) && ((cyc / 3) % 2 == 1);
      @(negedge clk);
      check($sformatf("rr req0_ready c%0d", cyc), {63'd0, bus.req0_ready}, {63'd0, e0});
      check($sformatf("rr req1_ready c%0d", cyc), {63'd0, bus.req1_ready}, {63'd0, e1});
      tick();
    end
    clear_inputs();
    do_reset();

    // back-pressure: wrap-around result held while rsp0_ready stays low
    set_req(0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    @(negedge clk);
    check("bp req0_ready", {63'd0, bus.req0_ready}, 64'd1);
    tick();
    bus.req0_valid = 1'b0;
    set_req(1, 2'b00, 64'd3, 64'd3);
    bus.rsp1_ready = 1'b1;   // non-owner, must be ignored
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
      check("bp rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
      check("bp rsp_data", bus.rsp_data, 64'd0);
      check("bp req1_ready", {63'd0, bus.req1_ready}, 64'd0);
      check("bp busy", {63'd0, bus.busy}, 64'd1);
      tick();
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp release rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
    tick();
    @(negedge clk);
    check("bp idle after release", {63'd0, bus.busy}, 64'd0);
    check("bp req1 granted after", {63'd0, bus.req1_ready}, 64'd1);
    bus.req1_valid = 1'b0;   // withdraw before the edge: no handshake
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    tick();
    @(negedge clk);
    check("bp withdrawn stays idle", {63'd0, bus.busy}, 64'd0);
    tick();

    // reset while in EXEC; pointer back to favour requester 0
    do_txn(1, 2'b00, 64'd10, 64'd20, 64'd30);   // last grant now 1
    do_txn(0, 2'b00, 64'd1, 64'd1, 64'd2);      // last grant now 0
    set_req(1, 2'b00, 64'd7, 64'd8);
    bus.rsp1_ready = 1'b0;
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("pre-reset in EXEC", {62'd0, state_dbg}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst busy", {63'd0, bus.busy}, 64'd0);
    check("rst alu_in1", bus.alu_in1, 64'd0);
    check("rst alu_in2", bus.alu_in2, 64'd0);
    check("rst alu_signal", {62'd0, bus.alu_signal}, 64'd0);
    check("rst rsp_data", bus.rsp_data, 64'd0);
    check("rst rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
    tick();
    rst = 1'b0;
    bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post-rst no rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
      tick();
    end
    set_req(0, 2'b00, 64'd1, 64'd2);
    set_req(1, 2'b00, 64'd3, 64'd4);
    @(negedge clk);
    check("post-rst contention req0_ready", {63'd0, bus.req0_ready}, 64'd1);
    check("post-rst contention req1_ready", {63'd0, bus.req1_ready}, 64'd0);
    tick();
    clear_inputs();
    bus.rsp0_ready = 1'b1;
    tick();
    @(negedge clk);
    check("post-rst rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
    check("post-rst rsp_data", bus.rsp_data, 64'd3);
    tick();
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
